// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: MEM pipeline stage running data-memory loads/stores (incl. byte read-modify-write) over req/ack.
module mem_stage_ctrl #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int DATA_W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              IN_VALID,
  input  logic [DATA_W-1:0] WRITE_BACK,
  input  logic [DATA_W-1:0] MEMORY,
  input  logic [DATA_W-1:0] REGISTER_VAL1,
  input  logic [DATA_W-1:0] OP1_ADDRESS,
  input  logic [DATA_W-1:0] ALU_RESULT_UPPER,
  input  logic [DATA_W-1:0] ALU_RESULT_LOWER,
  output logic [DATA_W-1:0] DMEM_ADDR,
  output logic [DATA_W-1:0] DMEM_WDATA,
  output logic              DMEM_WE,
  output logic              DMEM_REQ,
  input  logic [DATA_W-1:0] DMEM_RDATA,
  input  logic              DMEM_ACK,
  output logic              STALL,
  output logic [DATA_W-1:0] WRITE_BACK_OUT,
  output logic [DATA_W-1:0] OP1_ADDRESS_OUT,
  output logic [DATA_W-1:0] ALU_RESULT_UPPER_OUT,
  output logic [DATA_W-1:0] ALU_RESULT_LOWER_OUT,
  output logic [DATA_W-1:0] MEM_DATA_OUT,
  output logic              OUT_VALID,
  output logic              MEM_FAULT
);
  typedef enum logic [2:0] {IDLE, RD, WR, RMW_RD, RMW_GAP, RMW_WR} state_t;
  localparam logic [15:0] TO = 16'(TIMEOUT_CYCLES);
  state_t state, n_state;
  logic fin, n_fin, done, ack, timeout, misalign, unused_mem;
  logic [15:0] cnt, n_cnt;
  logic [DATA_W-1:0] hold, n_hold, l_wb, l_op1, l_up, l_lo;
  logic [1:0] l_mode;
  logic [7:0] l_val, rd_byte;
  logic [DATA_W-1:0] rd_fmt, merged;
  logic [DATA_W-1:0] n_addr, n_wdata, n_wb, n_op1, n_up, n_lo, n_data;
  logic n_we, n_req, n_valid, n_fault;
  assign unused_mem = ^MEMORY[DATA_W-1:4];
  assign STALL = state != IDLE;
  assign ack = DMEM_REQ && DMEM_ACK;
  assign misalign = MEMORY[1:0] != 2'b00 && !MEMORY[2] && ALU_RESULT_LOWER[0];
  assign timeout = TIMEOUT_CYCLES != 0 && DMEM_REQ && !DMEM_ACK && cnt + 16'd1 == TO;
  assign rd_byte = l_lo[0] ? DMEM_RDATA[15:8] : DMEM_RDATA[7:0];
  assign rd_fmt = !l_mode[0] ? DMEM_RDATA : {{(DATA_W-8){l_mode[1] & rd_byte[7]}}, rd_byte};
  assign merged = l_lo[0] ? {l_val, DMEM_RDATA[7:0]} : {DMEM_RDATA[15:8], l_val};
  always_comb begin
    n_state = state;
    n_fin = fin;
    n_cnt = DMEM_REQ && !DMEM_ACK ? cnt + 16'd1 : 16'd0;
    n_hold = hold;
    n_addr = DMEM_ADDR;
    n_wdata = DMEM_WDATA;
    n_we = DMEM_WE;
    n_req = DMEM_REQ && !DMEM_ACK;
    n_wb = WRITE_BACK_OUT;
    n_op1 = OP1_ADDRESS_OUT;
    n_up = ALU_RESULT_UPPER_OUT;
    n_lo = ALU_RESULT_LOWER_OUT;
    n_data = MEM_DATA_OUT;
    n_valid = 1'b0;
    n_fault = MEM_FAULT;
    done = 1'b0;
    case (state)
      IDLE: if (IN_VALID) begin
        if (MEMORY[1:0] == 2'b00 || misalign) begin
          {n_wb, n_op1, n_up, n_lo} = {WRITE_BACK, OP1_ADDRESS, ALU_RESULT_UPPER, ALU_RESULT_LOWER};
          n_data = '0;
          n_valid = 1'b1;
          n_fault = MEM_FAULT | misalign;
        end else begin
          n_addr = {ALU_RESULT_LOWER[DATA_W-1:1], 1'b0};
          n_wdata = REGISTER_VAL1;
          n_we = MEMORY[1] & ~MEMORY[2];
          n_req = 1'b1;
          n_state = !MEMORY[1] ? RD : MEMORY[2] ? RMW_RD : WR;
        end
      end
      RMW_GAP: begin
        n_state = RMW_WR;
        n_wdata = hold;
        n_we = 1'b1;
        n_req = 1'b1;
      end
      default:
        // fin marks the extra completion cycle after the final ACK
        if (fin) done = 1'b1;
        else if (timeout) begin
          n_req = 1'b0;
          n_cnt = 16'd0;
          n_fault = 1'b1;
          done = 1'b1;
        end else if (ack) begin
          n_fin = state != RMW_RD;
          n_hold = state == RD ? rd_fmt : state == RMW_RD ? merged : '0;
          n_state = state == RMW_RD ? RMW_GAP : state;
        end
    endcase
    if (done) begin
      {n_wb, n_op1, n_up, n_lo} = {l_wb, l_op1, l_up, l_lo};
      n_data = fin ? hold : '0;
      n_valid = 1'b1;
      n_state = IDLE;
      n_fin = 1'b0;
    end
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      state <= IDLE;
      fin <= 1'b0;
      cnt <= 16'd0;
      hold <= '0;
      l_wb <= '0;
      l_op1 <= '0;
      l_up <= '0;
      l_lo <= '0;
      l_mode <= 2'b00;
      l_val <= 8'h00;
      DMEM_ADDR <= '0;
      DMEM_WDATA <= '0;
      DMEM_WE <= 1'b0;
      DMEM_REQ <= 1'b0;
      WRITE_BACK_OUT <= '0;
      OP1_ADDRESS_OUT <= '0;
      ALU_RESULT_UPPER_OUT <= '0;
      ALU_RESULT_LOWER_OUT <= '0;
      MEM_DATA_OUT <= '0;
      OUT_VALID <= 1'b0;
      MEM_FAULT <= 1'b0;
    end else begin
      state <= n_state;
      fin <= n_fin;
      cnt <= n_cnt;
      hold <= n_hold;
      if (state == IDLE) begin
        l_wb <= WRITE_BACK;
        l_op1 <= OP1_ADDRESS;
        l_up <= ALU_RESULT_UPPER;
        l_lo <= ALU_RESULT_LOWER;
        l_mode <= MEMORY[3:2];
        l_val <= REGISTER_VAL1[7:0];
      end
      DMEM_ADDR <= n_addr;
      DMEM_WDATA <= n_wdata;
      DMEM_WE <= n_we;
      DMEM_REQ <= n_req;
      WRITE_BACK_OUT <= n_wb;
      OP1_ADDRESS_OUT <= n_op1;
      ALU_RESULT_UPPER_OUT <= n_up;
      ALU_RESULT_LOWER_OUT <= n_lo;
      MEM_DATA_OUT <= n_data;
      OUT_VALID <= n_valid;
      MEM_FAULT <= n_fault;
    end
endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: directed + random checks of mem_stage_ctrl against a word-array memory model.
module tb_mem_stage_ctrl;
  logic CLK = 1'b0, RST = 1'b1, IN_VALID = 1'b0, DMEM_ACK = 1'b0;
  logic [15:0] WRITE_BACK = '0, MEMORY = '0, REGISTER_VAL1 = '0, OP1_ADDRESS = '0;
  logic [15:0] ALU_RESULT_UPPER = '0, ALU_RESULT_LOWER = '0, DMEM_RDATA = '0;
  logic [15:0] DMEM_ADDR, DMEM_WDATA, WRITE_BACK_OUT, OP1_ADDRESS_OUT;
  logic [15:0] ALU_RESULT_UPPER_OUT, ALU_RESULT_LOWER_OUT, MEM_DATA_OUT;
  logic DMEM_WE, DMEM_REQ, STALL, OUT_VALID, MEM_FAULT;
  logic [15:0] mem_model [256];
  int checks = 0, failures = 0;
  bit fault_exp = 1'b0;

  mem_stage_ctrl dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .WRITE_BACK(WRITE_BACK), .MEMORY(MEMORY),
    .REGISTER_VAL1(REGISTER_VAL1), .OP1_ADDRESS(OP1_ADDRESS), .ALU_RESULT_UPPER(ALU_RESULT_UPPER),
    .ALU_RESULT_LOWER(ALU_RESULT_LOWER), .DMEM_ADDR(DMEM_ADDR), .DMEM_WDATA(DMEM_WDATA),
    .DMEM_WE(DMEM_WE), .DMEM_REQ(DMEM_REQ), .DMEM_RDATA(DMEM_RDATA), .DMEM_ACK(DMEM_ACK),
    .STALL(STALL), .WRITE_BACK_OUT(WRITE_BACK_OUT), .OP1_ADDRESS_OUT(OP1_ADDRESS_OUT),
    .ALU_RESULT_UPPER_OUT(ALU_RESULT_UPPER_OUT), .ALU_RESULT_LOWER_OUT(ALU_RESULT_LOWER_OUT),
    .MEM_DATA_OUT(MEM_DATA_OUT), .OUT_VALID(OUT_VALID), .MEM_FAULT(MEM_FAULT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // d1/d2: REQ cycle (1-based) in which ACK is given for first/second access; 0 = never ACK
  task automatic do_op(input logic [15:0] wb, m, v, op1, up, lo, input int d1, d2);
    logic [15:0] old, exp_data, exp_wd;
    logic [7:0] b, idx;
    int lat, exp_lat, stalls, phase, run, gap, exp_ph;
    bit is_mem, wr, bt, mis, to;
    is_mem = m[1:0] != 2'b00;
    wr = m[1];
    bt = m[2];
    mis = is_mem && !bt && lo[0];
    idx = lo[8:1];
    old = mem_model[idx];
    b = lo[0] ? old[15:8] : old[7:0];
    exp_data = '0;
    exp_lat = 0;
    exp_ph = 0;
    to = 1'b0;
    if (is_mem && !mis) begin
      exp_ph = 1;
      if (!wr || !bt) begin
        exp_lat = d1 == 0 ? 16 : d1 + 1;
        to = d1 == 0;
        if (!wr && d1 != 0) exp_data = !bt ? old : m[3] ? {{8{b[7]}}, b} : {8'h00, b};
      end else if (d1 == 0) begin
        exp_lat = 16;
        to = 1'b1;
      end else begin
        exp_ph = 2;
        exp_lat = d1 + 1 + (d2 == 0 ? 16 : d2 + 1);
        to = d2 == 0;
      end
    end
    exp_wd = !bt ? v : lo[0] ? {v[7:0], old[7:0]} : {old[15:8], v[7:0]};
    fault_exp = fault_exp | mis | to;
    WRITE_BACK = wb; MEMORY = m; REGISTER_VAL1 = v; OP1_ADDRESS = op1;
    ALU_RESULT_UPPER = up; ALU_RESULT_LOWER = lo; IN_VALID = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    lat = 0; stalls = 0; phase = 0; run = 0; gap = 0;
    while (!OUT_VALID && lat < 100) begin
      DMEM_ACK = 1'b0;
      if (STALL) stalls++;
      if (DMEM_REQ) begin
        if (run == 0) begin
          phase++;
          chk("addr", DMEM_ADDR, {lo[15:1], 1'b0});
          chk("we", DMEM_WE, phase == 2 || (wr && !bt));
          if (phase == 2 || (wr && !bt)) chk("wdata", DMEM_WDATA, exp_wd);
          if (phase == 2) chk("gap", gap, 1);
        end
        run++;
        if (run == (phase == 1 ? d1 : d2)) begin
          DMEM_ACK = 1'b1;
          DMEM_RDATA = mem_model[idx];
          if (wr && (phase == 2 || !bt)) mem_model[idx] = exp_wd;
        end
      end else begin
        if (phase == 1) gap++;
        run = 0;
      end
      @(posedge CLK); #1;
      lat++;
    end
    DMEM_ACK = 1'b0;
    chk("latency", lat, exp_lat);
    chk("stall_cycles", stalls, exp_lat);
    chk("req_phases", phase, exp_ph);
    chk("mem_data", MEM_DATA_OUT, exp_data);
    chk("wb_out", WRITE_BACK_OUT, wb);
    chk("op1_out", OP1_ADDRESS_OUT, op1);
    chk("upper_out", ALU_RESULT_UPPER_OUT, up);
    chk("lower_out", ALU_RESULT_LOWER_OUT, lo);
    chk("fault", MEM_FAULT, fault_exp);
    chk("stall_done", STALL, 1'b0);
    chk("req_done", DMEM_REQ, 1'b0);
    @(posedge CLK); #1;
    chk("valid_pulse", OUT_VALID, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_model[i] = 16'($urandom);
    #1 RST = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_req", DMEM_REQ, 1'b0);
    chk("rst_stall", STALL, 1'b0);
    chk("rst_valid", OUT_VALID, 1'b0);
    chk("rst_fault", MEM_FAULT, 1'b0);
    chk("rst_addr", DMEM_ADDR, 16'h0000);
    chk("rst_data", MEM_DATA_OUT, 16'h0000);
    RST = 1'b1;
    do_op(16'h0001, 16'h0000, 16'h0003, 16'h0004, 16'h0005, 16'h0006, 1, 1);
    mem_model[8'h20] = 16'hBEEF;
    do_op(16'h0011, 16'h0001, 16'h0000, 16'h0007, 16'h0022, 16'h0040, 3, 0);
    mem_model[8'h20] = 16'h80FF;
    do_op(16'h0012, 16'h000D, 16'h0000, 16'h0008, 16'h0033, 16'h0041, 1, 0);
    do_op(16'h0013, 16'h0005, 16'h0000, 16'h0009, 16'h0044, 16'h0041, 2, 0);
    mem_model[8'h20] = 16'h1234;
    do_op(16'h0014, 16'h0006, 16'h00AB, 16'h000A, 16'h0055, 16'h0040, 1, 2);
    do_op(16'h0015, 16'h0001, 16'h0000, 16'h000B, 16'h0066, 16'h0040, 1, 0);
    do_op(16'h0016, 16'h0003, 16'h5A5A, 16'h000C, 16'h0077, 16'h0042, 1, 0);
    do_op(16'h0017, 16'h0001, 16'h0000, 16'h000D, 16'h0088, 16'h0100, 0, 0);
    do_op(16'h0018, 16'h0001, 16'h0000, 16'h000E, 16'h0099, 16'h0041, 1, 0);
    // asynchronous reset while a read is outstanding
    WRITE_BACK = 16'h00F0; MEMORY = 16'h0001; ALU_RESULT_LOWER = 16'h0060; IN_VALID = 1'b1;
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    repeat (2) @(posedge CLK);
    #3;
    chk("req_before_rst", DMEM_REQ, 1'b1);
    RST = 1'b0;
    #1;
    chk("mid_rst_req", DMEM_REQ, 1'b0);
    chk("mid_rst_stall", STALL, 1'b0);
    chk("mid_rst_valid", OUT_VALID, 1'b0);
    chk("mid_rst_fault", MEM_FAULT, 1'b0);
    chk("mid_rst_addr", DMEM_ADDR, 16'h0000);
    chk("mid_rst_wb", WRITE_BACK_OUT, 16'h0000);
    @(posedge CLK); #1;
    RST = 1'b1;
    fault_exp = 1'b0;
    do_op(16'h0021, 16'h0002, 16'hCAFE, 16'h0001, 16'h0002, 16'h0080, 2, 0);
    do_op(16'h0022, 16'h0001, 16'h0000, 16'h0003, 16'h0004, 16'h0080, 1, 0);
    for (int i = 0; i < 60; i++)
      do_op(16'($urandom), 16'($urandom_range(0, 15)), 16'($urandom), 16'($urandom),
            16'($urandom), 16'($urandom), int'($urandom_range(1, 4)), int'($urandom_range(1, 4)));
    do_op(16'h0031, 16'h0006, 16'h00C3, 16'h0002, 16'h0003, 16'h0091, 2, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mem_stage_ctrl.md
Name: mem_stage_ctrl

Overview:
Memory-access stage sitting directly downstream of the EX/MEM pipeline buffer and upstream of the MEM/WB buffer. Consumes the buffered WRITE_BACK/MEMORY/REGISTER_VAL1/OP1_ADDRESS/ALU_RESULT fields and runs data-memory loads and stores over a req/ack handshake, including read-modify-write for byte stores. Holds the EX/MEM buffer via STALL while busy and presents registered results plus OUT_VALID to the MEM/WB buffer.

Parameters:
TIMEOUT_CYCLES, 16, cycles REQ may stay high without ACK before abort; 0 disables the timeout.
DATA_W, 16, data/address/control field width; fixed 16 in this design.

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-low
IN_VALID  in  1  EX/MEM buffer holds a real instruction
WRITE_BACK  in  16  write-back control word, passed through
MEMORY  in  16  memory control: [0] read, [1] write, [2] byte mode, [3] sign-extend byte load
REGISTER_VAL1  in  16  store data
OP1_ADDRESS  in  16  destination register id, passed through
ALU_RESULT_UPPER  in  16  upper ALU result, passed through
ALU_RESULT_LOWER  in  16  byte address for memory ops; passed through
DMEM_ADDR  out  16  word-aligned byte address
DMEM_WDATA  out  16  write data
DMEM_WE  out  1  1 = write, 0 = read
DMEM_REQ  out  1  request, held until ACK
DMEM_RDATA  in  16  read data, valid with ACK
DMEM_ACK  in  1  one-cycle completion pulse
STALL  out  1  drives the EX/MEM buffer WRITE_ENABLE low (hold)
WRITE_BACK_OUT, OP1_ADDRESS_OUT, ALU_RESULT_UPPER_OUT, ALU_RESULT_LOWER_OUT  out  16 each  registered pass-through
MEM_DATA_OUT  out  16  load result; 0 for non-loads
OUT_VALID  out  1  one-cycle valid to MEM/WB buffer
MEM_FAULT  out  1  sticky fault flag

Behaviour:
- Reset (RST=0, async): all outputs 0, state IDLE, MEM_FAULT cleared, timeout counter 0. REQ drops immediately even mid-transaction.
- States: IDLE, RD, WR, RMW_RD, RMW_GAP, RMW_WR. STALL = (state != IDLE), decoded from registered state only.
- IDLE, edge with IN_VALID=0: OUT_VALID<=0, other outputs hold.
- IDLE, IN_VALID=1, MEMORY[1:0]=00: pass-through fields registered, MEM_DATA_OUT<=0, OUT_VALID<=1. Latency 1 cycle, no stall.
- IDLE, memory op: latch all input fields internally. Write bit has priority when both [0] and [1] are set. DMEM_ADDR <= {ALU_RESULT_LOWER[15:1],0}, REQ<=1.
  - Read → RD, WE=0.
  - Word write → WR, WE=1, WDATA=REGISTER_VAL1.
  - Byte write → RMW_RD, WE=0.
- Misalignment: word op (MEMORY[2]=0) with ALU_RESULT_LOWER[0]=1 issues no request. MEM_FAULT<=1, result completes in 1 cycle with MEM_DATA_OUT=0.
- Handshake: ACK is sampled only while REQ=1. ACK is allowed in the first REQ cycle. ADDR/WDATA/WE are stable while REQ=1. REQ deasserts on the edge where ACK is sampled.
- RD + ACK: MEM_DATA_OUT <= formatted data, OUT_VALID<=1, → IDLE.
  - Word: RDATA.
  - Byte: select [15:8] if addr[0]=1, else [7:0]; sign-extend if MEMORY[3]=1, else zero-extend.
- WR + ACK: OUT_VALID<=1, MEM_DATA_OUT<=0, → IDLE.
- RMW_RD + ACK: merged <= RDATA with the selected byte replaced by REGISTER_VAL1[7:0]; → RMW_GAP (REQ low exactly 1 cycle). Then RMW_WR: REQ=1, WE=1, WDATA=merged. ACK → complete as WR.
- OUT_VALID=0 while busy (bubble). Completion cycle is the last STALL=1 cycle. The next instruction is accepted in IDLE on the following edge.
- Minimum latencies, counted from the accept edge to the OUT_VALID edge:
  - Load or word store: 2 cycles.
  - Byte store: 4 cycles.
- Timeout: counter runs while REQ=1 and ACK=0, and clears on ACK or on leaving a REQ state. Reaching TIMEOUT_CYCLES: REQ<=0, MEM_FAULT<=1, OUT_VALID<=1, MEM_DATA_OUT<=0, → IDLE.
- MEM_FAULT stays set until reset.

Test Plan:
- Non-memory pass-through: IN_VALID=1, MEMORY=0, fields 0001..0006 → next edge outputs equal inputs, MEM_DATA_OUT=0000, OUT_VALID=1, STALL never high.
- Word load: MEMORY=0001, ALU_RESULT_LOWER=0040, ACK after 3 cycles with RDATA=BEEF → DMEM_ADDR=0040, STALL high 4 cycles, MEM_DATA_OUT=BEEF, single OUT_VALID pulse.
- Signed byte load: MEMORY=000D, addr=0041, RDATA=80FF → MEM_DATA_OUT=FF80; with MEMORY=0005 → 0080.
- Byte store RMW: MEMORY=0006, addr=0040, REGISTER_VAL1=00AB, read ACK RDATA=1234 → one REQ-low gap cycle, then write WDATA=12AB with WE=1; ACK → OUT_VALID.
- Timeout and misalignment: never ACK → REQ drops after 16 cycles, MEM_FAULT=1, OUT_VALID pulse. Separately, word load at addr 0041 → no REQ, MEM_FAULT=1.
- Reset mid-op: RST low during RD with REQ=1 → REQ, STALL and outputs 0 immediately, state IDLE; after release a new word store proceeds normally.
